// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer_pkg
//  Description : Shared types and constants for the sequential multiplier:
//                FSM state encoding, ALU opcodes and iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_sequencer_pkg;

    // Number of shift-add iterations for a 32x32 product
    localparam int ITERATIONS = 32;

    // ALU operation codes (3-bit control field)
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_sequencer_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer_alu
//  Description : Combinational 32-bit ALU. The multiplier only uses ADD, but
//                the full opcode set is kept so the block stays drop-in
//                compatible with the datapath ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer_alu
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    localparam int SH_W = $clog2(WIDTH);

    // Opcode decode; result defaults to pass-through of operand A
    always_comb begin
        o_result = i_a;
        case (i_ctrl)
            ALU_PASS: o_result = i_a;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLL:  o_result = i_a << i_b[SH_W-1:0];
            default:  o_result = i_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer
//  Description : Sequential 32x32 -> 64 shift-add multiplier (MULT/MULTU).
//                Signed operands are converted to magnitudes, multiplied
//                unsigned over 32 iterations, then the product is negated
//                when the operand signs differ.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERATIONS);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               sgn_q,    sgn_d;
    logic               neg_q,    neg_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;

    logic [WIDTH-1:0]   w_alu_sum;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_result;

    // Accumulate adder; only ADD is ever requested
    mult_sequencer_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_ctrl   (ALU_ADD),
        .i_a      (acc_hi_q),
        .i_b      (mcand_q),
        .o_result (w_alu_sum)
    );

    // Partial-product add is taken only when the current multiplier bit is set;
    // the carry out is recovered from unsigned wrap-around of the sum
    assign w_sum    = mplier_q[0] ? w_alu_sum : acc_hi_q;
    assign w_carry  = mplier_q[0] & (w_alu_sum < acc_hi_q);
    assign w_prod   = {acc_hi_q, acc_lo_q};
    assign w_result = neg_q ? (~w_prod + 1'b1) : w_prod;

    assign hi = hi_q;
    assign lo = lo_q;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state, datapath updates and status outputs
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        sgn_d    = sgn_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    sgn_d    = SIGNED_EN & is_signed;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Magnitude of the most negative value wraps to itself, which is
                // the correct unsigned magnitude
                if (sgn_q) begin
                    mcand_d  = mcand_q[WIDTH-1]  ? (~mcand_q + 1'b1)  : mcand_q;
                    mplier_d = mplier_q[WIDTH-1] ? (~mplier_q + 1'b1) : mplier_q;
                    neg_d    = mcand_q[WIDTH-1] ^ mplier_q[WIDTH-1];
                end else begin
                    neg_d    = 1'b0;
                end
                acc_hi_d = '0;
                acc_lo_d = '0;
                count_d  = '0;
                state_d  = S_CALC;
            end
            S_CALC: begin
                acc_hi_d = {w_carry, w_sum[WIDTH-1:1]};
                acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(ITERATIONS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                {hi_d, lo_d} = w_result;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_sequencer
//  Description : Directed self-checking bench for mult_sequencer. A second
//                instance with SIGNED_EN=0 shares the stimulus to show the
//                unsigned override.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy,  done;
    logic [31:0] hi,    lo;
    logic        busy2, done2;
    logic [31:0] hi2,   lo2;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] exp_prev;

    mult_sequencer #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    mult_sequencer #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy2),
        .done      (done2),
        .hi        (hi2),
        .lo        (lo2)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply, check latency, held outputs during CALC and result
    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit repulse);
        int cyc;
        int extra;
        bit got;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        cyc       = 0;
        got       = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (repulse && cyc == 10) begin
                start = 1'b1;
                op_a  = 32'd7;
                op_b  = 32'd9;
            end
            if (repulse && cyc == 11) start = 1'b0;
            if (cyc == 20) begin
                check_val({tag, "_busy"}, 64'(busy), 64'd1);
                check_val({tag, "_hold"}, {hi, lo}, exp_prev);
            end
            if (done) got = 1'b1;
        end
        check_val({tag, "_latency"}, 64'(cyc), 64'd35);
        check_val({tag, "_result"}, {hi, lo}, exp);
        exp_prev = exp;
        @(posedge clk);
        #1;
        check_val({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        if (repulse) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check_val({tag, "_no_requeue"}, 64'(extra), 64'd0);
        end
    endtask

    // Directed sequence
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        exp_prev  = '0;
        #12;
        check_val("reset_status", {62'd0, busy, done}, 64'd0);
        check_val("reset_result", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u3x5",    1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F, 1'b0);
        run_op("uffxff",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("sm1xm1",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        run_op("smin_x2", 1'b1, 32'h8000_0000, 32'd2,        64'hFFFF_FFFF_0000_0000, 1'b0);
        run_op("smin_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op("sm7x6",   1'b1, 32'hFFFF_FFF9, 32'd6,        64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        check_val("signed_off_m7x6", {hi2, lo2}, 64'h0000_0005_FFFF_FFD6);
        run_op("zero",    1'b1, 32'd0,        32'd5,        64'h0, 1'b0);
        run_op("s5xm3",   1'b1, 32'd5,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("u_big",   1'b0, 32'h1234_5678, 32'h10,       64'h0000_0001_2345_6780, 1'b0);
        run_op("ignore",  1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F, 1'b1);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = 32'd9;
        op_b      = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_status", {62'd0, busy, done}, 64'd0);
        check_val("midrst_result", {hi, lo}, 64'd0);
        exp_prev = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 1'b0, 32'd4, 32'd4, 64'd16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
